// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared pipeline header. Holds the default register-file
//               geometry and the hard-wired zero register address used by
//               every pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  // Default data width of every architectural register.
  localparam int unsigned RF_DWIDTH   = 32;
  // Default register address width (2**RF_AWIDTH registers).
  localparam int unsigned RF_AWIDTH   = 5;
  // Address of the register that always reads as zero.
  localparam int unsigned RF_X0_ADDR  = 0;
  // Width of the retired write-back slot counter.
  localparam int unsigned RF_CNT_W    = 32;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Two-read / one-write architectural register file with
//               write-first bypass, registered source operands, pipeline
//               stall/flush handling and a retired-slot counter.
// Revision    : 1.0 - initial release
//
// Ports
//   rf_clk          in   clock, all state updates on rising edge
//   rf_rst          in   synchronous active-high reset
//   rf_i_ce         in   write-back slot valid
//   rf_i_we         in   write-back requests a register write
//   rf_i_rd_addr    in   destination register address
//   rf_i_rd_data    in   destination register data
//   rf_i_stall      in   pipeline stall (hold everything)
//   rf_i_flush      in   pipeline flush (kill write and operand valid)
//   rf_i_rs_en      in   decode requests a source-operand read
//   rf_i_rs1_addr   in   source register 1 address
//   rf_i_rs2_addr   in   source register 2 address
//   rf_o_rs1_data   out  registered source operand 1
//   rf_o_rs2_data   out  registered source operand 2
//   rf_o_rs_valid   out  operands valid this cycle
//   rf_o_retire_cnt out  count of accepted write-back slots (wraps)
// ============================================================================
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DWIDTH = RF_DWIDTH,
  parameter int unsigned AWIDTH = RF_AWIDTH
) (
  input  logic              rf_clk,
  input  logic              rf_rst,
  input  logic              rf_i_ce,
  input  logic              rf_i_we,
  input  logic [AWIDTH-1:0] rf_i_rd_addr,
  input  logic [DWIDTH-1:0] rf_i_rd_data,
  input  logic              rf_i_stall,
  input  logic              rf_i_flush,
  input  logic              rf_i_rs_en,
  input  logic [AWIDTH-1:0] rf_i_rs1_addr,
  input  logic [AWIDTH-1:0] rf_i_rs2_addr,
  output logic [DWIDTH-1:0] rf_o_rs1_data,
  output logic [DWIDTH-1:0] rf_o_rs2_data,
  output logic              rf_o_rs_valid,
  output logic [31:0]       rf_o_retire_cnt
);

  localparam int unsigned NREGS = 1 << AWIDTH;
  localparam logic [AWIDTH-1:0] C_X0_ADDR = AWIDTH'(RF_X0_ADDR);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DWIDTH-1:0]   regs_q [NREGS];
  logic [DWIDTH-1:0]   rs1_data_q, rs1_data_d;
  logic [DWIDTH-1:0]   rs2_data_q, rs2_data_d;
  logic                rs_valid_q, rs_valid_d;
  logic [RF_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic accept_w;
  logic commit_w;
  logic read_w;

  // Flush kills the slot outright; stall merely postpones it.
  assign accept_w = rf_i_ce & ~rf_i_stall & ~rf_i_flush;
  // Writes to x0 are accepted (and counted) but never land in the array.
  assign commit_w = accept_w & rf_i_we & (rf_i_rd_addr != C_X0_ADDR);
  assign read_w   = rf_i_rs_en & ~rf_i_stall;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    rs_valid_d   = rs_valid_q;
    retire_cnt_d = retire_cnt_q;

    if (accept_w) begin
      retire_cnt_d = retire_cnt_q + RF_CNT_W'(1);
    end

    if (rf_i_flush) begin
      // Operand data is kept, only the valid flag is dropped.
      rs_valid_d = 1'b0;
    end else if (!rf_i_stall) begin
      rs_valid_d = read_w;
      if (read_w) begin
        // Write-first bypass, replicated for each read port. commit_w already
        // excludes x0, so a matching address here is always a real register.
        if (commit_w && (rf_i_rd_addr == rf_i_rs1_addr)) begin
          rs1_data_d = rf_i_rd_data;
        end else begin
          rs1_data_d = regs_q[rf_i_rs1_addr];
        end

        if (commit_w && (rf_i_rd_addr == rf_i_rs2_addr)) begin
          rs2_data_d = rf_i_rd_data;
        end else begin
          rs2_data_d = regs_q[rf_i_rs2_addr];
        end
      end
    end
    // Stall without flush: every output keeps its previous value.
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge rf_clk) begin
    if (rf_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_w) begin
      regs_q[rf_i_rd_addr] <= rf_i_rd_data;
    end
  end

  always_ff @(posedge rf_clk) begin
    if (rf_rst) begin
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      rs_valid_q   <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      rs_valid_q   <= rs_valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign rf_o_rs1_data   = rs1_data_q;
  assign rf_o_rs2_data   = rs2_data_q;
  assign rf_o_rs_valid   = rs_valid_q;
  assign rf_o_retire_cnt = retire_cnt_q;

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. Table of stimulus records
//               with expected next-cycle outputs, routed through a scoreboard
//               queue, plus hand-written counter-wrap and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          rf_clk;
  logic          rf_rst;
  logic          rf_i_ce;
  logic          rf_i_we;
  logic [AW-1:0] rf_i_rd_addr;
  logic [DW-1:0] rf_i_rd_data;
  logic          rf_i_stall;
  logic          rf_i_flush;
  logic          rf_i_rs_en;
  logic [AW-1:0] rf_i_rs1_addr;
  logic [AW-1:0] rf_i_rs2_addr;
  logic [DW-1:0] rf_o_rs1_data;
  logic [DW-1:0] rf_o_rs2_data;
  logic          rf_o_rs_valid;
  logic [31:0]   rf_o_retire_cnt;

  reg_file #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .rf_clk          (rf_clk),
    .rf_rst          (rf_rst),
    .rf_i_ce         (rf_i_ce),
    .rf_i_we         (rf_i_we),
    .rf_i_rd_addr    (rf_i_rd_addr),
    .rf_i_rd_data    (rf_i_rd_data),
    .rf_i_stall      (rf_i_stall),
    .rf_i_flush      (rf_i_flush),
    .rf_i_rs_en      (rf_i_rs_en),
    .rf_i_rs1_addr   (rf_i_rs1_addr),
    .rf_i_rs2_addr   (rf_i_rs2_addr),
    .rf_o_rs1_data   (rf_o_rs1_data),
    .rf_o_rs2_data   (rf_o_rs2_data),
    .rf_o_rs_valid   (rf_o_rs_valid),
    .rf_o_retire_cnt (rf_o_retire_cnt)
  );

  initial rf_clk = 1'b0;
  always #5 rf_clk = ~rf_clk;

  typedef struct {
    logic          rst, ce, we, stall, flush, rs_en;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] wdata;
    logic [DW-1:0] e_rs1, e_rs2;
    logic          e_valid;
    logic [31:0]   e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [DW-1:0] rs1, rs2;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rf_clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, ce, we, input logic [AW-1:0] rd,
                              input logic [DW-1:0] wdata, input logic stall, flush, rs_en,
                              input logic [AW-1:0] rs1, rs2,
                              input logic [DW-1:0] e_rs1, e_rs2,
                              input logic e_valid, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.ce = ce; v.we = we; v.rd = rd; v.wdata = wdata;
    v.stall = stall; v.flush = flush; v.rs_en = rs_en; v.rs1 = rs1; v.rs2 = rs2;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expected outcome, clock it and
  // check the outcome against the oldest scoreboard entry.
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    rf_rst        = v.rst;
    rf_i_ce       = v.ce;
    rf_i_we       = v.we;
    rf_i_rd_addr  = v.rd;
    rf_i_rd_data  = v.wdata;
    rf_i_stall    = v.stall;
    rf_i_flush    = v.flush;
    rf_i_rs_en    = v.rs_en;
    rf_i_rs1_addr = v.rs1;
    rf_i_rs2_addr = v.rs2;
    e.name = name; e.rs1 = v.e_rs1; e.rs2 = v.e_rs2; e.valid = v.e_valid; e.cnt = v.e_cnt;
    sb_q.push_back(e);
    tick();
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      cmp({e.name, ".rs1"},   rf_o_rs1_data,   e.rs1);
      cmp({e.name, ".rs2"},   rf_o_rs2_data,   e.rs2);
      cmp({e.name, ".valid"}, 32'(rf_o_rs_valid), 32'(e.valid));
      cmp({e.name, ".cnt"},   rf_o_retire_cnt, e.cnt);
    end
  endtask

  vec_t vecs[14];
  vec_t v;

  initial begin
    rf_rst = 1'b1; rf_i_ce = 1'b0; rf_i_we = 1'b0; rf_i_rd_addr = '0;
    rf_i_rd_data = '0; rf_i_stall = 1'b0; rf_i_flush = 1'b0; rf_i_rs_en = 1'b0;
    rf_i_rs1_addr = '0; rf_i_rs2_addr = '0;

    //            rst ce we rd  wdata          st fl en rs1 rs2  e_rs1          e_rs2          v  cnt
    vecs[0]  = mk(0, 0, 0, 0,  32'h0,          0, 0, 1, 5,  0,  32'h0,         32'h0,         1, 0);
    vecs[1]  = mk(0, 1, 1, 5,  32'hDEADBEEF,   0, 0, 0, 0,  0,  32'h0,         32'h0,         0, 1);
    vecs[2]  = mk(0, 0, 0, 0,  32'h0,          0, 0, 1, 5,  0,  32'hDEADBEEF,  32'h0,         1, 1);
    vecs[3]  = mk(0, 1, 1, 7,  32'h12345678,   0, 0, 1, 7,  7,  32'h12345678,  32'h12345678,  1, 2);
    vecs[4]  = mk(0, 1, 1, 0,  32'hFFFFFFFF,   0, 0, 1, 0,  5,  32'h0,         32'hDEADBEEF,  1, 3);
    vecs[5]  = mk(0, 1, 0, 9,  32'h1,          0, 0, 0, 0,  0,  32'h0,         32'hDEADBEEF,  0, 4);
    vecs[6]  = mk(0, 1, 1, 3,  32'hA5A5A5A5,   1, 0, 1, 3,  3,  32'h0,         32'hDEADBEEF,  0, 4);
    vecs[7]  = mk(0, 1, 1, 3,  32'hA5A5A5A5,   0, 1, 1, 3,  3,  32'h0,         32'hDEADBEEF,  0, 4);
    vecs[8]  = mk(0, 0, 0, 0,  32'h0,          0, 0, 1, 3,  7,  32'h0,         32'h12345678,  1, 4);
    vecs[9]  = mk(0, 1, 1, 3,  32'hA5A5A5A5,   1, 1, 1, 5,  5,  32'h0,         32'h12345678,  0, 4);
    vecs[10] = mk(0, 0, 0, 0,  32'h0,          0, 0, 1, 3,  3,  32'h0,         32'h0,         1, 4);
    vecs[11] = mk(0, 1, 1, 31, 32'hCAFEF00D,   0, 0, 1, 31, 5,  32'hCAFEF00D,  32'hDEADBEEF,  1, 5);
    vecs[12] = mk(0, 1, 1, 31, 32'h0BADF00D,   0, 0, 1, 5,  31, 32'hDEADBEEF,  32'h0BADF00D,  1, 6);
    vecs[13] = mk(0, 0, 0, 0,  32'h0,          0, 0, 1, 31, 9,  32'h0BADF00D,  32'h0,         1, 6);

    tick();
    tick();
    cmp("reset.rs1",   rf_o_rs1_data,   32'h0);
    cmp("reset.rs2",   rf_o_rs2_data,   32'h0);
    cmp("reset.valid", 32'(rf_o_rs_valid), 32'h0);
    cmp("reset.cnt",   rf_o_retire_cnt, 32'h0);

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Counter wrap: preload near the top, then two accepted slots.
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_q;
    cmp("wrap.preload", rf_o_retire_cnt, 32'hFFFF_FFFE);
    v = mk(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0BADF00D, 32'h0, 0, 32'hFFFF_FFFF);
    apply("wrap.acc1", v);
    v = mk(0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0BADF00D, 32'h0, 0, 32'h0);
    apply("wrap.acc2", v);

    // Reset overrides a simultaneous write and read.
    v = mk(0, 1, 1, 9, 32'h11, 0, 0, 0, 0, 0, 32'h0BADF00D, 32'h0, 0, 32'h1);
    apply("rst.wr9", v);
    v = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 9, 31, 32'h11, 32'h0BADF00D, 1, 32'h1);
    apply("rst.rd9", v);
    v = mk(1, 1, 1, 9, 32'h22, 0, 0, 1, 9, 9, 32'h0, 32'h0, 0, 32'h0);
    apply("rst.assert", v);
    v = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 9, 31, 32'h0, 32'h0, 1, 32'h0);
    apply("rst.rd9_after", v);
    // First cycles after reset behave normally, including the bypass.
    v = mk(0, 1, 1, 9, 32'h33, 0, 0, 1, 9, 0, 32'h33, 32'h0, 1, 32'h1);
    apply("rst.bypass", v);
    v = mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 9, 32'h0, 32'h33, 1, 32'h1);
    apply("rst.rd_back", v);

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard leftover entries=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL take parameter DWIDTH, default 32, meaning data width of every register and data port.
REQ-002 The block SHALL take parameter AWIDTH, default 5, meaning register address width (2^AWIDTH registers).
REQ-003 The block SHALL have port rf_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rf_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port rf_i_ce, input, 1 bit: write-back slot valid (clock enable from the write-back stage).
REQ-006 The block SHALL have port rf_i_we, input, 1 bit: write-back requests a register write.
REQ-007 The block SHALL have port rf_i_rd_addr, input, AWIDTH: destination register address.
REQ-008 The block SHALL have port rf_i_rd_data, input, DWIDTH: destination register data.
REQ-009 The block SHALL have ports rf_i_stall and rf_i_flush, input, 1 bit each: pipeline stall and flush.
REQ-010 The block SHALL have port rf_i_rs_en, input, 1 bit: decode requests a source-operand read.
REQ-011 The block SHALL have ports rf_i_rs1_addr and rf_i_rs2_addr, input, AWIDTH each: source register addresses.
REQ-012 The block SHALL have ports rf_o_rs1_data and rf_o_rs2_data, output, DWIDTH each: registered source operands.
REQ-013 The block SHALL have port rf_o_rs_valid, output, 1 bit: operands on rf_o_rs1/rs2_data are valid this cycle.
REQ-014 The block SHALL have port rf_o_retire_cnt, output, 32 bits: count of accepted write-back slots.

Function
REQ-015 The block SHALL accept a write-back slot when rf_i_ce=1, rf_i_stall=0 and rf_i_flush=0; this is the accept condition.
REQ-016 The block SHALL commit a write when the accept condition holds, rf_i_we=1 and rf_i_rd_addr!=0; the register takes rf_i_rd_data at that edge.
REQ-017 Register 0 SHALL always read as 0; writes addressed to 0 are discarded without error.
REQ-018 The block SHALL perform a read when rf_i_rs_en=1 and rf_i_stall=0; rf_o_rs1_data and rf_o_rs2_data are updated at the next edge (1-cycle latency).
REQ-019 When a read and a committed write target the same nonzero address in one cycle, the read SHALL return the new write data (write-first bypass), independently for rs1 and rs2.
REQ-020 rf_o_rs_valid SHALL be 1 in the cycle after a read per REQ-018 with rf_i_flush=0, and 0 otherwise.
REQ-021 When rf_i_flush=1, no write SHALL commit and rf_o_rs_valid SHALL be 0 next cycle; rf_o_rs1/rs2_data hold their previous values.
REQ-022 When rf_i_stall=1 and rf_i_flush=0, all outputs and all registers SHALL hold their values.
REQ-023 When stall and flush are both 1, flush SHALL take precedence for rf_o_rs_valid (0); registers hold.
REQ-024 rf_o_retire_cnt SHALL increment by 1 on every accepted slot, including rf_i_we=0 and writes to register 0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Each read address SHALL be taken modulo 2^AWIDTH; no out-of-range condition exists.

Reset
REQ-026 While rf_rst=1 at an edge, all registers, rf_o_rs1_data, rf_o_rs2_data, rf_o_rs_valid and rf_o_retire_cnt SHALL become 0.
REQ-027 rf_rst SHALL override every simultaneous write, read, stall or flush; no write commits in a reset cycle.
REQ-028 In the first cycle after rf_rst deasserts, the block SHALL accept writes and reads normally.

Structure
REQ-029 DWIDTH/AWIDTH defaults and the x0 address constant SHALL reside in the shared header already included by the pipeline stages; no new package types are required.
REQ-030 The block SHALL be a single module with no sub-modules; the read-bypass mux is replicated inline for rs1 and rs2.

Verification
REQ-031 Reset, then read rs1=5, rs2=0 with rs_en=1 -> next cycle rs1_data=0, rs2_data=0, rs_valid=1, retire_cnt=0.
REQ-032 Write x5=0xDEADBEEF (ce=1, we=1), next cycle read rs1=5 -> rs1_data=0xDEADBEEF one cycle later; retire_cnt=1.
REQ-033 Same cycle: write x7=0x12345678 and read rs1=7, rs2=7 -> both outputs 0x12345678 next cycle; write x0=0xFFFFFFFF with read rs1=0 -> 0.
REQ-034 Write x3=0xA5A5A5A5 with stall=1, then with flush=1 -> reading x3 returns 0, retire_cnt unchanged, rs_valid=0 after the flush cycle.
REQ-035 Preload retire_cnt to 0xFFFFFFFE via 2 fewer accepts in a forced-state test, apply 2 accepts -> retire_cnt=0 after wrap.
REQ-036 Write x9=0x11, then assert rf_rst together with a write x9=0x22 -> after reset x9 reads 0, all outputs 0.
